// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: instruction field layout,
// opcode values and the sequencer state encoding.
package proc_pkg;

    localparam int CODE_W     = 23;
    localparam int OP_W       = 4;
    localparam int REG_ADDR_W = 3;
    localparam int IMM_W      = 16;

    localparam int OP_MSB  = 22;
    localparam int OP_LSB  = 19;
    localparam int RX_MSB  = 18;
    localparam int RX_LSB  = 16;
    localparam int RY_MSB  = 15;
    localparam int RY_LSB  = 13;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_LOAD = 4'b0001;
    localparam logic [OP_W-1:0] OP_MOV  = 4'b0010;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // True for the opcodes that commit a result to R[rx] in WB.
    function automatic logic writes_reg(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_MOV) || (op == OP_ADD);
    endfunction

    // True for opcodes outside the defined instruction set.
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OP_ADD;
    endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// Eight-entry register file: one synchronous write port, two combinational
// operand read ports and one combinational debug read port.
module reg_file_8x16 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [8];

    // Clear every register on reset, otherwise commit the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/fetch_exec_unit.sv
// Multi-cycle sequencer: fetches a ROM word, decodes it, executes LOAD/MOV/ADD
// against the register file and retires one instruction every four cycles.
module fetch_exec_unit
    import proc_pkg::*;
#(
    parameter int PC_W         = 5,
    parameter int DATA_W       = 16,
    parameter bit HALT_ON_WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [22:0]       code,
    output logic [PC_W-1:0]   address,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              halted,
    output logic              carry,
    output logic              illegal,
    output logic [7:0]        retired
);

    state_t state, state_next;

    logic [PC_W-1:0]       pc;
    logic [CODE_W-1:0]     ir;
    logic [DATA_W-1:0]     opa, opb, result;
    logic [DATA_W-1:0]     ra_data, rb_data;
    logic [DATA_W:0]       sum;
    logic [OP_W-1:0]       op;
    logic [REG_ADDR_W-1:0] rx, ry;
    logic [DATA_W-1:0]     imm;
    logic                  wr_en;
    logic                  stop_here;

    assign op        = ir[OP_MSB:OP_LSB];
    assign rx        = ir[RX_MSB:RX_LSB];
    assign ry        = ir[RY_MSB:RY_LSB];
    assign imm       = DATA_W'(ir[IMM_MSB:IMM_LSB]);
    assign sum       = {1'b0, opa} + {1'b0, opb};
    assign stop_here = HALT_ON_WRAP && (&pc);
    assign address   = pc;

    reg_file_8x16 #(.DATA_W(DATA_W)) u_regs (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .waddr    (rx),
        .wdata    (result),
        .ra_addr  (rx),
        .ra_data  (ra_data),
        .rb_addr  (ry),
        .rb_data  (rb_data),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data)
    );

    // State register; reset always returns the sequencer to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing plus the status and write-enable outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        halted     = 1'b0;
        wr_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy       = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                busy       = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                busy       = 1'b1;
                state_next = ST_WB;
            end
            ST_WB: begin
                busy       = 1'b1;
                wr_en      = writes_reg(op);
                state_next = stop_here ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: IR capture, operand latch, execute, retire and PC step.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            opa     <= '0;
            opb     <= '0;
            result  <= '0;
            carry   <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir <= code;
                end
                ST_DECODE: begin
                    opa <= ra_data;
                    opb <= rb_data;
                    if (is_illegal(op)) begin
                        illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (op)
                        OP_LOAD: result <= imm;
                        OP_MOV:  result <= opb;
                        OP_ADD: begin
                            result <= sum[DATA_W-1:0];
                            carry  <= sum[DATA_W];
                        end
                        default: result <= '0;
                    endcase
                end
                ST_WB: begin
                    retired <= retired + 8'd1;
                    if (!stop_here) begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_exec_unit.sv
// Self-checking bench for fetch_exec_unit: one halting instance and one
// wrapping instance, each fed from its own bench-side ROM array.
module tb_fetch_exec_unit;

    typedef struct packed {
        logic [3:0][22:0] prog;
        logic [2:0]       sel;
        logic [15:0]      val;
        logic             carry;
        logic             illegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst1 = 1'b1, run1 = 1'b0;
    logic        rst0 = 1'b1, run0 = 1'b0;
    logic [2:0]  dbg_sel1 = 3'd0, dbg_sel0 = 3'd0;
    logic [22:0] code1, code0;
    logic [4:0]  address1, address0;
    logic [15:0] dbg_data1, dbg_data0;
    logic        busy1, halted1, carry1, illegal1;
    logic        busy0, halted0, carry0, illegal0;
    logic [7:0]  retired1, retired0;

    logic [22:0] rom1 [32];
    logic [22:0] rom0 [32];

    int tests = 0;
    int fails = 0;
    int cycles, addr_bad;
    logic [15:0] r0_at3, r0_at4;
    int mreg [8];
    int mcarry, millegal;
    vec_t vecs [5];

    assign code1 = rom1[address1];
    assign code0 = rom0[address0];

    always #5 clk = ~clk;

    fetch_exec_unit #(.PC_W(5), .DATA_W(16), .HALT_ON_WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .run(run1), .code(code1), .address(address1),
        .dbg_sel(dbg_sel1), .dbg_data(dbg_data1), .busy(busy1), .halted(halted1),
        .carry(carry1), .illegal(illegal1), .retired(retired1)
    );

    fetch_exec_unit #(.PC_W(5), .DATA_W(16), .HALT_ON_WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .run(run0), .code(code0), .address(address0),
        .dbg_sel(dbg_sel0), .dbg_data(dbg_data0), .busy(busy0), .halted(halted0),
        .carry(carry0), .illegal(illegal0), .retired(retired0)
    );

    function automatic logic [22:0] i_load(input logic [2:0] rx, input logic [15:0] imm);
        return {4'b0001, rx, imm};
    endfunction

    function automatic logic [22:0] i_mov(input logic [2:0] rx, input logic [2:0] ry);
        return {4'b0010, rx, ry, 13'b0};
    endfunction

    function automatic logic [22:0] i_add(input logic [2:0] rx, input logic [2:0] ry);
        return {4'b0011, rx, ry, 13'b0};
    endfunction

    function automatic vec_t mk(input logic [22:0] p0, input logic [22:0] p1,
                                input logic [22:0] p2, input logic [22:0] p3,
                                input logic [2:0] sel, input logic [15:0] val,
                                input logic c, input logic il);
        vec_t v;
        v.prog    = {p3, p2, p1, p0};
        v.sel     = sel;
        v.val     = val;
        v.carry   = c;
        v.illegal = il;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        run1 = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b0;
    endtask

    task automatic clear_rom1();
        for (int k = 0; k < 32; k++) rom1[k] = 23'd0;
    endtask

    // Starts the halting instance from IDLE and follows it edge by edge until
    // HALT, a bound, or a reset pulse injected after edge index reset_at.
    task automatic applyStimulus(input int reset_at);
        int  expa;
        bit  done;
        dbg_sel1 = 3'd0;
        run1     = 1'b1;
        cycles   = 0;
        addr_bad = 0;
        done     = 1'b0;
        for (int m = 0; m < 400 && !done; m++) begin
            @(posedge clk); #1;
            cycles = m + 1;
            run1   = 1'b0;
            expa   = (m / 4 > 31) ? 31 : m / 4;
            if (int'(address1) != expa) addr_bad++;
            if (m == 3) r0_at3 = dbg_data1;
            if (m == 4) r0_at4 = dbg_data1;
            if (m == reset_at) begin
                checkOutput("reset_point_address", {27'd0, address1}, 32'd11);
                checkOutput("reset_point_busy", {31'd0, busy1}, 32'd1);
                rst1 = 1'b1;
                @(posedge clk); #1;
                rst1 = 1'b0;
                done = 1'b1;
            end
            if (halted1) done = 1'b1;
        end
    endtask

    // Reference execution of rom1: architectural effect of each instruction in order.
    task automatic model_exec();
        logic [22:0] w;
        int op, rx, ry, s;
        for (int i = 0; i < 8; i++) mreg[i] = 0;
        mcarry   = 0;
        millegal = 0;
        for (int k = 0; k < 32; k++) begin
            w  = rom1[k];
            op = int'(w[22:19]);
            rx = int'(w[18:16]);
            ry = int'(w[15:13]);
            if (op == 1) begin
                mreg[rx] = int'(w[15:0]);
            end else if (op == 2) begin
                mreg[rx] = mreg[ry];
            end else if (op == 3) begin
                s        = mreg[rx] + mreg[ry];
                mcarry   = (s >= 65536) ? 1 : 0;
                mreg[rx] = s % 65536;
            end else if (op != 0) begin
                millegal = 1;
            end
        end
    endtask

    task automatic check_regs1(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel1 = 3'(i);
            #1;
            checkOutput($sformatf("%s_R%0d", tag, i), {16'd0, dbg_data1}, mreg[i]);
        end
    endtask

    task automatic load_standard();
        clear_rom1();
        rom1[0]  = i_load(3'd0, 16'd12);
        rom1[1]  = i_load(3'd1, 16'd9);
        rom1[2]  = i_load(3'd2, 16'd3);
        rom1[3]  = i_load(3'd3, 16'd20);
        rom1[4]  = i_load(3'd4, 16'd13);
        rom1[5]  = i_load(3'd5, 16'd21);
        rom1[6]  = i_load(3'd6, 16'd25);
        rom1[7]  = i_load(3'd7, 16'd30);
        rom1[8]  = i_mov(3'd0, 3'd4);
        rom1[9]  = i_mov(3'd5, 3'd7);
        rom1[10] = i_mov(3'd2, 3'd1);
        rom1[11] = i_add(3'd3, 3'd0);
    endtask

    task automatic check_standard(input string tag);
        mreg[0] = 13; mreg[1] = 9;  mreg[2] = 9;  mreg[3] = 33;
        mreg[4] = 13; mreg[5] = 30; mreg[6] = 25; mreg[7] = 30;
        checkOutput({tag, "_cycles"}, cycles, 129);
        checkOutput({tag, "_halted"}, {31'd0, halted1}, 32'd1);
        checkOutput({tag, "_retired"}, {24'd0, retired1}, 32'd32);
        checkOutput({tag, "_carry"}, {31'd0, carry1}, 32'd0);
        checkOutput({tag, "_addr_seq_errors"}, addr_bad, 0);
        check_regs1(tag);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gate_bad, zero_bad;
        bit halt_seen;
        logic [22:0] w;
        int sel;

        vecs[0] = mk(i_load(3'd1, 16'hFFFF), i_load(3'd2, 16'h0002), i_add(3'd1, 3'd2), 23'd0,
                     3'd1, 16'h0001, 1'b1, 1'b0);
        vecs[1] = mk(i_load(3'd1, 16'd7), i_add(3'd1, 3'd1), 23'd0, 23'd0,
                     3'd1, 16'd14, 1'b0, 1'b0);
        vecs[2] = mk(i_load(3'd2, 16'd5), 23'd0, 23'd0, {4'b1010, 3'd2, 16'h1234},
                     3'd2, 16'd5, 1'b0, 1'b1);
        vecs[3] = mk(i_load(3'd3, 16'h00AA), i_load(3'd4, 16'h0055), i_mov(3'd4, 3'd3), 23'd0,
                     3'd4, 16'h00AA, 1'b0, 1'b0);
        vecs[4] = mk(i_load(3'd5, 16'h8000), i_add(3'd5, 3'd5), i_load(3'd6, 16'd1), 23'd0,
                     3'd5, 16'h0000, 1'b1, 1'b0);

        for (int k = 0; k < 32; k++) rom0[k] = 23'd0;
        rom0[0] = i_load(3'd1, 16'd3);

        // Reset state and run gating
        clear_rom1();
        reset1();
        checkOutput("reset_address", {27'd0, address1}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy1}, 32'd0);
        checkOutput("reset_halted", {31'd0, halted1}, 32'd0);
        checkOutput("reset_retired", {24'd0, retired1}, 32'd0);
        checkOutput("reset_carry_illegal", {30'd0, carry1, illegal1}, 32'd0);
        zero_bad = 0;
        for (int i = 0; i < 8; i++) begin
            dbg_sel1 = 3'(i);
            #1;
            if (dbg_data1 != 16'd0) zero_bad++;
        end
        checkOutput("reset_regs_nonzero", zero_bad, 0);
        gate_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (busy1 || address1 != 5'd0) gate_bad++;
        end
        checkOutput("run_low_gating", gate_bad, 0);

        // Standard program, latency and address stability
        load_standard();
        reset1();
        applyStimulus(-1);
        checkOutput("first_write_before_wb", {16'd0, r0_at3}, 32'd0);
        checkOutput("first_write_after_wb", {16'd0, r0_at4}, 32'd12);
        check_standard("std");

        // Reset during EXEC of the ADD at address 11, then re-run
        reset1();
        applyStimulus(46);
        checkOutput("midrst_busy", {31'd0, busy1}, 32'd0);
        checkOutput("midrst_address", {27'd0, address1}, 32'd0);
        checkOutput("midrst_retired", {24'd0, retired1}, 32'd0);
        checkOutput("midrst_halted", {31'd0, halted1}, 32'd0);
        zero_bad = 0;
        for (int i = 0; i < 8; i++) begin
            dbg_sel1 = 3'(i);
            #1;
            if (dbg_data1 != 16'd0) zero_bad++;
        end
        checkOutput("midrst_regs_nonzero", zero_bad, 0);
        @(posedge clk); #1;
        applyStimulus(-1);
        check_standard("rerun");

        // Table-driven short programs
        for (int v = 0; v < 5; v++) begin
            clear_rom1();
            for (int k = 0; k < 4; k++) rom1[k] = vecs[v].prog[k];
            reset1();
            applyStimulus(-1);
            checkOutput($sformatf("vec%0d_halted", v), {31'd0, halted1}, 32'd1);
            checkOutput($sformatf("vec%0d_retired", v), {24'd0, retired1}, 32'd32);
            dbg_sel1 = vecs[v].sel;
            #1;
            checkOutput($sformatf("vec%0d_reg", v), {16'd0, dbg_data1}, {16'd0, vecs[v].val});
            checkOutput($sformatf("vec%0d_carry", v), {31'd0, carry1}, {31'd0, vecs[v].carry});
            checkOutput($sformatf("vec%0d_illegal", v), {31'd0, illegal1}, {31'd0, vecs[v].illegal});
        end

        // Randomized programs against the reference model
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 32; k++) begin
                sel = int'($urandom_range(0, 5));
                w   = {4'b0000, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535))};
                case (sel)
                    1:       w[22:19] = 4'b0001;
                    2:       w[22:19] = 4'b0010;
                    3, 4:    w[22:19] = 4'b0011;
                    5:       w[22:19] = 4'($urandom_range(4, 15));
                    default: w = 23'd0;
                endcase
                rom1[k] = w;
            end
            model_exec();
            reset1();
            applyStimulus(-1);
            checkOutput($sformatf("rnd%0d_retired", p), {24'd0, retired1}, 32'd32);
            checkOutput($sformatf("rnd%0d_carry", p), {31'd0, carry1}, mcarry);
            checkOutput($sformatf("rnd%0d_illegal", p), {31'd0, illegal1}, millegal);
            check_regs1($sformatf("rnd%0d", p));
        end

        // Wrap mode on the second instance
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        run0 = 1'b1;
        halt_seen = 1'b0;
        for (int m = 0; m <= 1024; m++) begin
            @(posedge clk); #1;
            run0 = 1'b0;
            if (halted0) halt_seen = 1'b1;
            if (m == 127) checkOutput("wrap_addr_31", {27'd0, address0}, 32'd31);
            if (m == 128) begin
                checkOutput("wrap_addr_0", {27'd0, address0}, 32'd0);
                checkOutput("wrap_retired_32", {24'd0, retired0}, 32'd32);
                checkOutput("wrap_busy", {31'd0, busy0}, 32'd1);
            end
            if (m == 1020) checkOutput("wrap_retired_255", {24'd0, retired0}, 32'd255);
            if (m == 1024) checkOutput("wrap_retired_0", {24'd0, retired0}, 32'd0);
        end
        checkOutput("wrap_never_halted", {31'd0, halt_seen}, 32'd0);
        dbg_sel0 = 3'd1;
        #1;
        checkOutput("wrap_R1", {16'd0, dbg_data0}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
